// File: rtl/bsg_dff_pipe_en.sv
// Elastic depth_p-stage register pipeline with per-stage valids, bubble collapsing and a global freeze.
// Optional synchronous flush of all stage valids when BSG_DFF_PIPE_CLEAR_EN is defined.
module bsg_dff_pipe_en #(
   parameter int width_p = 62,
   parameter int depth_p = 2
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic                             en_i,
`ifdef BSG_DFF_PIPE_CLEAR_EN
   input  logic                             clear_i,
`endif
   input  logic [width_p-1:0]               data_i,
   input  logic                             v_i,
   output logic                             ready_o,
   output logic [width_p-1:0]               data_o,
   output logic                             v_o,
   input  logic                             ready_i,
   output logic [$clog2(depth_p+1)-1:0]     count_o
);

   localparam int cnt_w = $clog2(depth_p + 1);

   // Handshake: a transfer happens on an edge where valid and ready are both 1
   // on that side; neither side's valid may depend on its own ready.

   logic                clear;
   logic                en_eff;
   logic [depth_p-1:0]  v;
   logic [depth_p-1:0]  load;
   logic [depth_p-1:0]  move;
   logic [width_p-1:0]  d [depth_p];
   logic                in_fire;
   logic                out_fire;

`ifdef BSG_DFF_PIPE_CLEAR_EN
   assign clear = clear_i;
`else
   assign clear = 1'b0;
`endif

   // A pending clear behaves like a disabled cycle for every handshake.
   assign en_eff = en_i & ~clear;

   always_comb begin
      move    = '0;
      load    = '0;
      ready_o = 1'b0;
      move[depth_p-1] = v[depth_p-1] & en_eff & ready_i;
      for (int k = depth_p - 2; k >= 0; k--) begin
         load[k+1] = en_eff & v[k] & (~v[k+1] | move[k+1]);
         move[k]   = load[k+1];
      end
      ready_o = en_eff & (~v[0] | move[0]);
      load[0] = v_i & ready_o;
   end

   assign in_fire  = load[0];
   assign out_fire = move[depth_p-1];

   assign v_o    = v[depth_p-1] & en_eff;
   assign data_o = d[depth_p-1];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v <= '0;
      end else if (clear) begin
         v <= '0;
      end else begin
         for (int k = 0; k < depth_p; k++) begin
            if (load[k])      v[k] <= 1'b1;
            else if (move[k]) v[k] <= 1'b0;
         end
      end
   end

   // Data registers are plain enabled flops: they only capture on load.
   for (genvar k = 0; k < depth_p; k++) begin : g_stage
      logic [width_p-1:0] upstream;
      if (k == 0) begin : g_head
         assign upstream = data_i;
      end else begin : g_body
         assign upstream = d[k-1];
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i)   d[k] <= '0;
         else if (load[k]) d[k] <= upstream;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_o <= '0;
      end else if (clear) begin
         count_o <= '0;
      end else if (in_fire && !out_fire) begin
         count_o <= count_o + cnt_w'(1);
      end else if (out_fire && !in_fire) begin
         count_o <= count_o - cnt_w'(1);
      end
   end

endmodule
